// File: rtl/issue_hazard_scoreboard.sv
// issue_hazard_scoreboard
// Dual-issue hazard controller in front of the register file. It tracks the
// in-flight even-pipe and odd-pipe destinations, each with a countdown to
// writeback. Every cycle it decides whether the issuing pair may proceed, and
// it registers six operand forward selects that the register file uses on the
// following cycle.
//
// Ports
//   clk                     clock
//   Reset                   synchronous active-high reset
//   Flush                   synchronous clear of all in-flight state
//   IssueE / IssueO         even / odd slot holds a valid instruction
//   RAE,RBE,RCE / RAO,...   source registers of each slot
//   UseE / UseO             source-valid masks {A,B,C}
//   RTE / RTO               destination registers
//   WrE / WrO               instruction writes its destination
//   LatE / LatO             issue-to-writeback latency (0 is taken as 1)
//   Stall                   combinational; the pair is not accepted
//   ForwardE1..ForwardO3    registered forward selects
//                           (01010 DataE, 11000 DataO, 00000 register path)
//   PairHazard              combinational; intra-pair RAW/WAW (decode error)
//   StallCount              count of stalled issue cycles
//
// Optional feature: define SCOREBOARD_STATS_EN to build the saturating stall
// counter. When it is not defined, StallCount is tied to zero.
module issue_hazard_scoreboard #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned ADDRW = 7,
  parameter int unsigned LATW  = 3
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             Flush,
  input  logic             IssueE,
  input  logic             IssueO,
  input  logic [ADDRW-1:0] RAE,
  input  logic [ADDRW-1:0] RBE,
  input  logic [ADDRW-1:0] RCE,
  input  logic [ADDRW-1:0] RAO,
  input  logic [ADDRW-1:0] RBO,
  input  logic [ADDRW-1:0] RCO,
  input  logic [2:0]       UseE,
  input  logic [2:0]       UseO,
  input  logic [ADDRW-1:0] RTE,
  input  logic [ADDRW-1:0] RTO,
  input  logic             WrE,
  input  logic             WrO,
  input  logic [LATW-1:0]  LatE,
  input  logic [LATW-1:0]  LatO,
  output logic             Stall,
  output logic [4:0]       ForwardE1,
  output logic [4:0]       ForwardE2,
  output logic [4:0]       ForwardE3,
  output logic [4:0]       ForwardO1,
  output logic [4:0]       ForwardO2,
  output logic [4:0]       ForwardO3,
  output logic             PairHazard,
  output logic [31:0]      StallCount
);

  localparam int unsigned NOPS = 6;
  localparam int unsigned IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [4:0]  FWD_E    = 5'b01010;
  localparam logic [4:0]  FWD_O    = 5'b11000;
  localparam logic [4:0]  FWD_NONE = 5'b00000;

  // Scoreboard storage, one set of slots per pipe.
  logic [DEPTH-1:0] e_vld;
  logic [DEPTH-1:0] o_vld;
  logic [ADDRW-1:0] e_reg [DEPTH];
  logic [ADDRW-1:0] o_reg [DEPTH];
  logic [LATW-1:0]  e_rem [DEPTH];
  logic [LATW-1:0]  o_rem [DEPTH];

  // Operand index order: 0..2 = even A,B,C; 3..5 = odd A,B,C.
  logic [ADDRW-1:0] op_addr [NOPS];
  logic [NOPS-1:0]  op_act;

  logic [NOPS-1:0]  fwd_e_hit;
  logic [NOPS-1:0]  fwd_o_hit;
  logic [NOPS-1:0]  blk_hit;

  logic             waw_e_hit;
  logic             waw_o_hit;
  logic             e_full;
  logic             o_full;
  logic [IDXW-1:0]  e_free_idx;
  logic [IDXW-1:0]  o_free_idx;

  logic             need_e;
  logic             need_o;
  logic             raw_stall;
  logic             accept;
  logic             alloc_e;
  logic             alloc_o;
  logic [LATW-1:0]  rem_init_e;
  logic [LATW-1:0]  rem_init_o;

  logic [4:0]       fwd_nxt [NOPS];
  logic [4:0]       fwd_q   [NOPS];

  // Gather the six operands and which of them are live this cycle.
  always_comb begin
    op_addr[0] = RAE;
    op_addr[1] = RBE;
    op_addr[2] = RCE;
    op_addr[3] = RAO;
    op_addr[4] = RBO;
    op_addr[5] = RCO;
    op_act = {IssueO & UseO[0], IssueO & UseO[1], IssueO & UseO[2],
              IssueE & UseE[0], IssueE & UseE[1], IssueE & UseE[2]};
  end

  // Classify each operand against both pipes. A producer one cycle from
  // writeback is forwardable; anything further out, or writing back right
  // now, lands too late for the read and must stall.
  always_comb begin
    fwd_e_hit = '0;
    fwd_o_hit = '0;
    blk_hit   = '0;
    for (int k = 0; k < int'(NOPS); k++) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (e_vld[i] && (e_reg[i] == op_addr[k])) begin
          if (e_rem[i] == LATW'(1)) fwd_e_hit[k] = 1'b1;
          else                      blk_hit[k]   = 1'b1;
        end
        if (o_vld[i] && (o_reg[i] == op_addr[k])) begin
          if (o_rem[i] == LATW'(1)) fwd_o_hit[k] = 1'b1;
          else                      blk_hit[k]   = 1'b1;
        end
      end
    end
  end

  // Destination conflicts against anything still in flight in either pipe.
  always_comb begin
    waw_e_hit = 1'b0;
    waw_o_hit = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if ((e_vld[i] && (e_reg[i] == RTE)) || (o_vld[i] && (o_reg[i] == RTE)))
        waw_e_hit = 1'b1;
      if ((e_vld[i] && (e_reg[i] == RTO)) || (o_vld[i] && (o_reg[i] == RTO)))
        waw_o_hit = 1'b1;
    end
  end

  // Lowest free slot per pipe; a slot in writeback is still occupied.
  always_comb begin
    e_free_idx = '0;
    o_free_idx = '0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (!e_vld[i]) e_free_idx = IDXW'(i);
      if (!o_vld[i]) o_free_idx = IDXW'(i);
    end
  end

  assign e_full = &e_vld;
  assign o_full = &o_vld;

  // Pair-wide stall decision and acceptance.
  always_comb begin
    need_e    = IssueE & WrE;
    need_o    = IssueO & WrO;
    raw_stall = |(op_act & blk_hit);
    Stall     = raw_stall
              | (need_e & (waw_e_hit | e_full))
              | (need_o & (waw_o_hit | o_full));
    accept    = (IssueE | IssueO) & ~Stall & ~Flush & ~Reset;
    alloc_e   = accept & need_e;
    alloc_o   = accept & need_o;
  end

  // Stored countdown is one less than the latency: the issue cycle itself
  // counts as the first step toward writeback.
  assign rem_init_e = (LatE == '0) ? '0 : (LatE - LATW'(1));
  assign rem_init_o = (LatO == '0) ? '0 : (LatO - LATW'(1));

  // Intra-pair dependence that the scoreboard cannot see; reported only.
  assign PairHazard = IssueE & IssueO & WrE &
                      ((UseO[2] & (RAO == RTE)) |
                       (UseO[1] & (RBO == RTE)) |
                       (UseO[0] & (RCO == RTE)) |
                       (WrO & (RTO == RTE)));

  // Forward select for each operand of an accepted pair.
  always_comb begin
    for (int k = 0; k < int'(NOPS); k++) begin
      fwd_nxt[k] = FWD_NONE;
      if (accept && op_act[k]) begin
        if (fwd_e_hit[k])      fwd_nxt[k] = FWD_E;
        else if (fwd_o_hit[k]) fwd_nxt[k] = FWD_O;
      end
    end
  end

  // Even-pipe slots: count down, retire at zero, allocate on accept.
  always_ff @(posedge clk) begin
    if (Reset || Flush) begin
      e_vld <= '0;
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (e_vld[i]) begin
          if (e_rem[i] == '0) e_vld[i] <= 1'b0;
          else                e_rem[i] <= e_rem[i] - LATW'(1);
        end
      end
      if (alloc_e) begin
        e_vld[e_free_idx] <= 1'b1;
        e_reg[e_free_idx] <= RTE;
        e_rem[e_free_idx] <= rem_init_e;
      end
    end
  end

  // Odd-pipe slots: same behaviour as the even pipe.
  always_ff @(posedge clk) begin
    if (Reset || Flush) begin
      o_vld <= '0;
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (o_vld[i]) begin
          if (o_rem[i] == '0) o_vld[i] <= 1'b0;
          else                o_rem[i] <= o_rem[i] - LATW'(1);
        end
      end
      if (alloc_o) begin
        o_vld[o_free_idx] <= 1'b1;
        o_reg[o_free_idx] <= RTO;
        o_rem[o_free_idx] <= rem_init_o;
      end
    end
  end

  // Registered forward selects; zero after any non-accepted cycle.
  always_ff @(posedge clk) begin
    if (Reset || Flush) begin
      for (int k = 0; k < int'(NOPS); k++) fwd_q[k] <= FWD_NONE;
    end else begin
      for (int k = 0; k < int'(NOPS); k++) fwd_q[k] <= fwd_nxt[k];
    end
  end

  assign ForwardE1 = fwd_q[0];
  assign ForwardE2 = fwd_q[1];
  assign ForwardE3 = fwd_q[2];
  assign ForwardO1 = fwd_q[3];
  assign ForwardO2 = fwd_q[4];
  assign ForwardO3 = fwd_q[5];

`ifdef SCOREBOARD_STATS_EN
  // Saturating count of cycles where a valid pair was held back.
  logic [31:0] stall_cnt;

  always_ff @(posedge clk) begin
    if (Reset) begin
      stall_cnt <= '0;
    end else if ((IssueE | IssueO) && Stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign StallCount = stall_cnt;
`else
  assign StallCount = '0;
`endif

endmodule
